// File: rtl/rat_int_pkg.sv
// rat_int_pkg: shared constants and types for the RAT interrupt controller.
// Holds register offsets, FSM state type and the "no vector" code.
package rat_int_pkg;

  localparam logic [1:0] OFS_MASK = 2'd0;
  localparam logic [1:0] OFS_PEND = 2'd1;
  localparam logic [1:0] OFS_VEC  = 2'd2;
  localparam logic [1:0] OFS_EDGE = 2'd3;

  // Sign-extends to all ones at any width.
  localparam int VEC_NONE = -1;

  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    GAP
  } state_t;

endpackage

// File: rtl/rat_int_prio_enc.sv
// rat_int_prio_enc: lowest-index priority encoder.
// idx is all ones and valid low when no request is set.
module rat_int_prio_enc
  import rat_int_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = W'(VEC_NONE);
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rat_int_ctrl.sv
// rat_int_ctrl: register-mapped multi-source interrupt controller.
// Define RAT_INT_SYNC_EN to add a 2-flop synchroniser on SRC.
module rat_int_ctrl
  import rat_int_pkg::*;
#(
  parameter int         NUM_SRC = 8,
  parameter int         DATA_W  = 8,
  parameter logic [7:0] BASE_ID = 8'hE0,
  parameter int         GAP_CYC = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] SRC,
  input  logic [7:0]         PORT_ID,
  input  logic [DATA_W-1:0]  OUT_PORT,
  input  logic               IO_STRB,
  output logic [DATA_W-1:0]  RD_DATA,
  output logic               RD_HIT,
  output logic               INT
);

  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] edge_q;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] pend_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] wdat;
  logic [NUM_SRC-1:0] req;
  logic [DATA_W-1:0]  vec;
  logic               act;
  logic               hit;
  logic               wr;
  logic [1:0]         ofs;
  logic               unused_data;

  state_t             state_q;
  state_t             state_d;
  logic [GAP_W-1:0]   cnt_q;
  logic [GAP_W-1:0]   cnt_d;
  logic               int_q;

  assign ofs  = PORT_ID[1:0];
  assign hit  = PORT_ID[7:2] == BASE_ID[7:2];
  assign wr   = IO_STRB & hit;
  assign wdat = OUT_PORT[NUM_SRC-1:0];
  assign w1c  = (wr && ofs == OFS_PEND) ? wdat : '0;

  assign unused_data = ^OUT_PORT;

`ifdef RAT_INT_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= SRC;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = SRC;
`endif

  // Edge bits: set beats W1C. Level bits follow the source.
  assign rise   = src_s & ~src_q;
  assign pend_d = (edge_q & ((pend_q & ~w1c) | rise))
                | (~edge_q & src_s);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask_q <= '0;
      pend_q <= '0;
      edge_q <= '1;
      src_q  <= '0;
    end else begin
      src_q  <= src_s;
      pend_q <= pend_d;
      if (wr && ofs == OFS_MASK) mask_q <= wdat;
      if (wr && ofs == OFS_EDGE) edge_q <= wdat;
    end
  end

  assign req = pend_q & mask_q;

  rat_int_prio_enc #(
    .N (NUM_SRC),
    .W (DATA_W)
  ) u_enc (
    .req   (req),
    .idx   (vec),
    .valid (act)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (act) state_d = ASSERT;
      end
      ASSERT: begin
        if (!act) begin
          if (GAP_CYC == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_W'(GAP_CYC);
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q - GAP_W'(1);
        if (cnt_q <= GAP_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      int_q   <= state_d == ASSERT;
    end
  end

  assign INT    = int_q;
  assign RD_HIT = hit;

  always_comb begin
    RD_DATA = '0;
    if (hit) begin
      unique case (ofs)
        OFS_MASK: RD_DATA = DATA_W'(mask_q);
        OFS_PEND: RD_DATA = DATA_W'(pend_q);
        OFS_VEC:  RD_DATA = vec;
        OFS_EDGE: RD_DATA = DATA_W'(edge_q);
      endcase
    end
  end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// tb_rat_int_ctrl: directed + random bench for rat_int_ctrl
// against a cycle-level behavioural model.
module tb_rat_int_ctrl;
  import rat_int_pkg::*;

  localparam int         NUM_SRC = 8;
  localparam int         DATA_W  = 8;
  localparam logic [7:0] BASE_ID = 8'hE0;
  localparam int         GAP_CYC = 2;
`ifdef RAT_INT_SYNC_EN
  localparam int SDLY = 2;
`else
  localparam int SDLY = 0;
`endif

  logic               CLK = 1'b0;
  logic               RESET;
  logic [NUM_SRC-1:0] SRC;
  logic [7:0]         PORT_ID;
  logic [DATA_W-1:0]  OUT_PORT;
  logic               IO_STRB;
  logic [DATA_W-1:0]  RD_DATA;
  logic               RD_HIT;
  logic               INT;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "rst";

  always #10 CLK = ~CLK;

  rat_int_ctrl #(
    .NUM_SRC (NUM_SRC),
    .DATA_W  (DATA_W),
    .BASE_ID (BASE_ID),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .SRC      (SRC),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .RD_DATA  (RD_DATA),
    .RD_HIT   (RD_HIT),
    .INT      (INT)
  );

  // Model: register contents, INT level and remaining quiet cycles.
  bit [NUM_SRC-1:0] m_mask, m_pend, m_edge, m_prev;
  bit [NUM_SRC-1:0] m_dly[$];
  bit               m_int;
  int               m_quiet;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mask  = '0;
    m_pend  = '0;
    m_edge  = '1;
    m_prev  = '0;
    m_int   = 1'b0;
    m_quiet = 0;
    m_dly   = {};
    repeat (SDLY) m_dly.push_back('0);
  endtask

  task automatic model_edge();
    bit [NUM_SRC-1:0] s;
    bit               busy;
    bit               wr;
    int               o;
    busy = (m_pend & m_mask) != 0;
    m_dly.push_back(SRC);
    s  = m_dly.pop_front();
    wr = IO_STRB && (PORT_ID / 4 == BASE_ID / 4);
    o  = PORT_ID % 4;
    if (m_int) begin
      if (!busy) begin
        m_int   = 1'b0;
        m_quiet = GAP_CYC;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (busy) begin
      m_int = 1'b1;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (m_edge[i]) begin
        if (wr && o == 1 && OUT_PORT[i]) m_pend[i] = 1'b0;
        if (s[i] && !m_prev[i]) m_pend[i] = 1'b1;
      end else begin
        m_pend[i] = s[i];
      end
    end
    m_prev = s;
    if (wr && o == 0) m_mask = OUT_PORT[NUM_SRC-1:0];
    if (wr && o == 3) m_edge = OUT_PORT[NUM_SRC-1:0];
  endtask

  function automatic logic [DATA_W-1:0] exp_reg(input int o);
    case (o)
      0: return DATA_W'(m_mask);
      1: return DATA_W'(m_pend);
      2: begin
        for (int i = 0; i < NUM_SRC; i++)
          if (m_mask[i] && m_pend[i]) return DATA_W'(i);
        return '1;
      end
      default: return DATA_W'(m_edge);
    endcase
  endfunction

  task automatic check_regs();
    for (int o = 0; o < 4; o++) begin
      PORT_ID = BASE_ID + 8'(o);
      #1;
      chk($sformatf("%s_rd%0d", phase, o), RD_DATA, exp_reg(o));
      chk($sformatf("%s_hit%0d", phase, o), RD_HIT, 1);
    end
    PORT_ID = BASE_ID + 8'd4;
    #1;
    chk({phase, "_miss_rd"}, RD_DATA, 0);
    chk({phase, "_miss_hit"}, RD_HIT, 0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
    IO_STRB = 1'b0;
    chk({phase, "_int"}, INT, m_int);
    check_regs();
  endtask

  task automatic wr(input logic [1:0] o, input logic [DATA_W-1:0] d);
    PORT_ID  = BASE_ID + 8'(o);
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [1:0] o, output logic [DATA_W-1:0] v);
    PORT_ID = BASE_ID + 8'(o);
    #1;
    v = RD_DATA;
  endtask

  logic [DATA_W-1:0] v;

  initial begin
    RESET    = 1'b1;
    SRC      = '0;
    PORT_ID  = '0;
    OUT_PORT = '0;
    IO_STRB  = 1'b0;
    model_reset();
    check_regs();
    rd(OFS_VEC, v);
    chk("rst_vec_ff", v, 8'hFF);
    rd(OFS_EDGE, v);
    chk("rst_edge_ff", v, 8'hFF);
    chk("rst_int", INT, 0);
    #19;
    RESET = 1'b0;

    phase = "s2";
    wr(OFS_MASK, 8'h05);
    SRC = 8'h04;
    tick();
    SRC = '0;
    repeat (SDLY) tick();
    rd(OFS_PEND, v);
    chk("s2_pend", v, 8'h04);
    chk("s2_int_lat", INT, 0);
    tick();
    chk("s2_int_on", INT, 1);
    rd(OFS_VEC, v);
    chk("s2_vec", v, 8'h02);
    wr(OFS_PEND, 8'h04);
    repeat (2) begin
      tick();
      chk("s2_gap_low", INT, 0);
    end
    repeat (4) tick();
    chk("s2_stay_low", INT, 0);

    phase = "s3";
    SRC = 8'h05;
    repeat (SDLY + 2) tick();
    chk("s3_int", INT, 1);
    rd(OFS_VEC, v);
    chk("s3_vec0", v, 8'h00);
    wr(OFS_PEND, 8'h01);
    rd(OFS_VEC, v);
    chk("s3_vec2", v, 8'h02);
    tick();
    chk("s3_int_hold", INT, 1);
    wr(OFS_PEND, 8'h04);
    tick();
    chk("s3_int_fall", INT, 0);
    SRC = '0;
    repeat (6) tick();

    phase = "s4";
    wr(OFS_EDGE, 8'hFE);
    wr(OFS_MASK, 8'h01);
    SRC = 8'h01;
    repeat (SDLY + 2) tick();
    chk("s4_int", INT, 1);
    wr(OFS_PEND, 8'h01);
    rd(OFS_PEND, v);
    chk("s4_w1c_ign", v, 8'h01);
    SRC = '0;
    repeat (SDLY + 2) tick();
    chk("s4_int_fall", INT, 0);
    rd(OFS_PEND, v);
    chk("s4_pend0", v, 8'h00);
    repeat (4) tick();

    phase = "s5";
    wr(OFS_EDGE, 8'hFF);
    wr(OFS_MASK, 8'h08);
    SRC = 8'h08;
    tick();
    SRC = '0;
    repeat (SDLY + 4) tick();
    SRC = 8'h08;
    repeat (SDLY) tick();
    wr(OFS_PEND, 8'h08);
    rd(OFS_PEND, v);
    chk("s5_set_wins", v, 8'h08);
    for (int n = 0; n < 20 && !m_int; n++) tick();
    chk("s5_wait_int", INT, 1);
    RESET = 1'b1;
    #1;
    chk("s5_rst_int", INT, 0);
    model_reset();
    phase = "s5rst";
    check_regs();
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    SRC   = '0;

    phase = "rnd";
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < NUM_SRC; b++)
        if ($urandom_range(0, 5) == 0) SRC[b] = ~SRC[b];
      if ($urandom_range(0, 3) == 0) begin
        PORT_ID = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                : BASE_ID + 8'($urandom_range(0, 3));
        OUT_PORT = DATA_W'($urandom);
        IO_STRB  = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rat_int_ctrl.md
Name: rat_int_ctrl

Overview:
- Parametrised multi-source interrupt controller for the RAT MCU; merges NUM_SRC request lines into the MCU's single INT input.
- Sits on the MCU I/O bus (PORT_ID/OUT_PORT/IO_STRB) as a register-mapped peripheral, with per-source mask, edge/level mode, W1C pending and a priority vector.
- Holds INT until software clears the request, then enforces a minimum deassert gap so back-to-back interrupts are seen as distinct.

Parameters:
- NUM_SRC, 8, number of interrupt sources; 1..DATA_W.
- DATA_W, 8, I/O bus data width.
- BASE_ID, 8'hE0, first PORT_ID of the 4-register block; must be 4-aligned.
- GAP_CYC, 2, INT low cycles after a clear before re-assertion; 0..15.

Ports:
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- SRC  in  NUM_SRC  interrupt request lines.
- PORT_ID  in  8  MCU I/O address.
- OUT_PORT  in  DATA_W  MCU write data.
- IO_STRB  in  1  MCU write strobe, one cycle.
- RD_DATA  out  DATA_W  read data, combinational on PORT_ID.
- RD_HIT  out  1  PORT_ID in block; top-level IN_PORT mux select.
- INT  out  1  registered interrupt request to MCU.

Behaviour:
- Register map (offset from BASE_ID):
  - +0 MASK: R/W; 1 = enabled.
  - +1 PENDING: R; write-1-to-clear.
  - +2 VECTOR: R only; index of lowest-numbered pending&mask bit, all-ones if none.
  - +3 EDGE_SEL: R/W; 1 = rising-edge, 0 = level.
  - Bits above NUM_SRC read 0 and ignore writes.
- Writes take effect at the CLK edge where IO_STRB=1 and PORT_ID matches; writes to VECTOR are ignored.
- Reads are combinational; RD_DATA = 0 when RD_HIT=0.
- Reset values: MASK=0, PENDING=0, EDGE_SEL=all ones, INT=0, state IDLE, gap counter 0, src_q=0. Reset acts immediately mid-operation; INT drops asynchronously.
- Edge mode:
  - src_q registers SRC every cycle.
  - A rising edge (SRC & ~src_q) sets PENDING at the same clock edge.
  - Latency: SRC high before edge k → PENDING bit visible after k; INT high after k+1.
- Level mode: PENDING bit tracks registered SRC every cycle; W1C has no effect.
- Simultaneous W1C and new edge on the same bit: set wins.
- MASK changes never alter PENDING.
- Any state may be preempted by RESET only.
- State machine (INT is registered, high only in ASSERT):
  - IDLE: if |(PENDING & MASK) → ASSERT.
  - ASSERT: hold INT=1 while |(PENDING & MASK); when it becomes 0 → GAP with counter=GAP_CYC, or → IDLE if GAP_CYC=0.
  - GAP: INT=0; decrement each cycle; at 0 → IDLE.
  - New pending during GAP stays latched and is serviced from IDLE.

Optional Feature:
- Macro: RAT_INT_SYNC_EN.
- Defined: each SRC bit passes through a 2-flop synchroniser (reset 0) before edge/level logic; all SRC→PENDING/INT latencies grow by 2 cycles.
- Undefined: SRC is treated as synchronous to CLK; no synchroniser flops.

Decomposition:
- Package rat_int_pkg holds:
  - Register offset constants: OFS_MASK=0, OFS_PEND=1, OFS_VEC=2, OFS_EDGE=3.
  - State enum typedef: IDLE, ASSERT, GAP.
  - VEC_NONE constant (all ones).
- One sub-module: rat_int_prio_enc, a parametrised lowest-index priority encoder producing VECTOR and a valid flag.

Test Plan:
- Reset, then read BASE_ID+0..+3 → 00, 00, FF, FF; INT=0.
- Write MASK=8'h05; pulse SRC[2] 1 cycle → PENDING=04 one edge later, INT=1 the edge after, VECTOR=02; write PENDING=04 → INT=0 for 2 cycles (GAP_CYC=2) and stays 0.
- SRC[0] and SRC[2] rise together with MASK=05 → VECTOR=00; clear bit0 → VECTOR=02, INT stays 1; clear bit2 → INT falls.
- EDGE_SEL=8'hFE, MASK=01, SRC[0] held high → INT=1; W1C bit0 ignored; drop SRC[0] → PENDING=00, INT falls, GAP entered.
- W1C bit3 in the same cycle as a new SRC[3] edge → PENDING[3] remains 1; assert RESET mid-ASSERT → INT=0 immediately, all registers at reset values.
- With RAT_INT_SYNC_EN defined, repeat scenario 2 → PENDING/INT appear 2 cycles later than without the macro.
